init_flash_rd_ctrl: RTL and testbench

// Flash read-burst engine directly downstream of the init RAM loader's flash request port.
// - Accepts one burst request (rden pulse + 25-bit byte addr + 24-bit length).
// - Splits it into chunks of at most CHUNK_BYTES on the flash command port.
// - Returns bytes as valid/last/data to the loader's consumers (cons/xfer/card/afpga loaders).
// - A watchdog aborts a stalled burst and flags an error.

---
 rtl/init_flash_pkg.sv | 28 ++
 rtl/init_flash_wdog.sv | 35 +++
 rtl/init_flash_rd_ctrl.sv | 151 +++++++++++++++
 tb/tb_init_flash_rd_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_flash_pkg.sv
// Shared types and helpers for the init flash read-burst engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, address/length widths, chunk sizing helper.
package init_flash_pkg;

    localparam int ADDR_W = 25;  // flash byte address width
    localparam int LEN_W  = 24;  // burst byte count width
    localparam int CLEN_W = 16;  // per-command chunk byte count width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2
    } state_e;

    // Size of the next flash command: whatever is left, capped at the chunk size.
    // The chunk size never exceeds 65535, so the result always fits CLEN_W.
    function automatic logic [CLEN_W-1:0] chunk_len(input logic [LEN_W-1:0] remaining,
                                                    input int unsigned      chunk_bytes);
        if (remaining > LEN_W'(chunk_bytes)) begin
            return CLEN_W'(chunk_bytes);
        end
        return remaining[CLEN_W-1:0];
    endfunction

endpackage

// File: rtl/init_flash_wdog.sv
// Stall watchdog: flags expiry after TIMEOUT_CYC enabled cycles without a clear.
// Latency: expire_o is combinational from the count register; acted on at the next edge.
// Backpressure: none; counter saturates at expiry until cleared or disabled.
//
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i restarts the count;
//        en_i allows counting (count held at zero while low); expire_o timeout reached.
module init_flash_wdog #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;

    // After a clear at edge E the count reaches TIMEOUT_CYC-1 at edge E+TIMEOUT_CYC-1,
    // so the owner acts on expiry exactly TIMEOUT_CYC cycles after the last clear.
    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i) begin
            cnt_q <= '0;
        end else if (!expire_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/init_flash_rd_ctrl.sv
// Flash read-burst engine: splits one burst into chunked flash commands, streams bytes back.
// Latency: rx byte to init_flash_valid/data is one cycle; command req appears one cycle after rden.
// Backpressure: none toward consumers; flash side handshakes via req/ack, stalls end in a watchdog abort.
//
// Ports: sys_clk/glbl_rst_n clock and async active-low reset;
//        init_flash_rden/addr/length burst request in; init_flash_valid/last/data byte stream out;
//        flash_busy burst in progress; flash_error sticky timeout flag;
//        flash_cmd_req/addr/len/ack chunk command handshake; flash_rx_valid/data bytes from flash.
module init_flash_rd_ctrl
    import init_flash_pkg::*;
#(
    parameter int unsigned CHUNK_BYTES = 256,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              sys_clk,
    input  logic              glbl_rst_n,
    input  logic              init_flash_rden,
    input  logic [ADDR_W-1:0] init_flash_addr,
    input  logic [LEN_W-1:0]  init_flash_length,
    output logic              init_flash_valid,
    output logic              init_flash_last,
    output logic [7:0]        init_flash_data,
    output logic              flash_busy,
    output logic              flash_error,
    output logic              flash_cmd_req,
    output logic [ADDR_W-1:0] flash_cmd_addr,
    output logic [CLEN_W-1:0] flash_cmd_len,
    input  logic              flash_cmd_ack,
    input  logic              flash_rx_valid,
    input  logic [7:0]        flash_rx_data
);

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [CLEN_W-1:0] chunk_cnt_q;
    logic              req_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [CLEN_W-1:0] cmd_len_q;
    logic              valid_q;
    logic              last_q;
    logic [7:0]        data_q;
    logic              error_q;

    logic              wd_clr;
    logic              wd_en;
    logic              wd_expire;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  remaining_dec;

    // Start of the following chunk; wraps naturally at 2^ADDR_W.
    assign next_addr     = cur_addr_q + ADDR_W'(cmd_len_q);
    assign remaining_dec = remaining_q - LEN_W'(1);

    // Watchdog runs only while a burst is active. Entry into REQ from IDLE starts
    // from zero because the count is held clear while disabled; every other state
    // entry coincides with an ack or an rx byte, which clear it explicitly.
    assign wd_en  = (state_q != ST_IDLE);
    assign wd_clr = ((state_q == ST_REQ)  && flash_cmd_ack) ||
                    ((state_q == ST_RECV) && flash_rx_valid);

    init_flash_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i    (sys_clk),
        .rst_ni   (glbl_rst_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            chunk_cnt_q <= '0;
            req_q       <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Zero-length requests are dropped without touching the error flag.
                    if (init_flash_rden && (init_flash_length != '0)) begin
                        cur_addr_q  <= init_flash_addr;
                        remaining_q <= init_flash_length;
                        error_q     <= 1'b0;
                        req_q       <= 1'b1;
                        cmd_addr_q  <= init_flash_addr;
                        cmd_len_q   <= chunk_len(init_flash_length, CHUNK_BYTES);
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coincident watchdog expiry.
                    if (flash_cmd_ack) begin
                        req_q       <= 1'b0;
                        chunk_cnt_q <= cmd_len_q;
                        state_q     <= ST_RECV;
                    end else if (wd_expire) begin
                        error_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // A byte arriving on the expiry cycle wins and keeps the burst alive.
                    if (flash_rx_valid) begin
                        valid_q     <= 1'b1;
                        data_q      <= flash_rx_data;
                        remaining_q <= remaining_dec;
                        chunk_cnt_q <= chunk_cnt_q - CLEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            last_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (chunk_cnt_q == CLEN_W'(1)) begin
                            cur_addr_q <= next_addr;
                            req_q      <= 1'b1;
                            cmd_addr_q <= next_addr;
                            cmd_len_q  <= chunk_len(remaining_dec, CHUNK_BYTES);
                            state_q    <= ST_REQ;
                        end
                    end else if (wd_expire) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign init_flash_valid = valid_q;
    assign init_flash_last  = last_q;
    assign init_flash_data  = data_q;
    assign flash_busy       = (state_q != ST_IDLE);
    assign flash_error      = error_q;
    assign flash_cmd_req    = req_q;
    assign flash_cmd_addr   = cmd_addr_q;
    assign flash_cmd_len    = cmd_len_q;

endmodule

// File: tb/tb_init_flash_rd_ctrl.sv
// Directed bench for init_flash_rd_ctrl with a byte/command scoreboard and a flash responder.
// Two instances: chunk 256 and chunk 16; only the selected one receives stimulus.
module tb_init_flash_rd_ctrl;

    localparam int unsigned TO_CYC = 200;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } byte_t;

    typedef struct packed {
        logic [24:0] a;
        logic [15:0] n;
    } cmd_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        rden;
    logic [24:0] addr;
    logic [23:0] len;
    logic        ack;
    logic        rxv;
    logic        rx_inj;
    logic [7:0]  rxd;

    logic        rden0, rden1, ack0, ack1, rxv0, rxv1;
    logic        v0, l0, b0, e0, rq0;
    logic        v1, l1, b1, e1, rq1;
    logic [7:0]  d0, d1;
    logic [24:0] ca0, ca1;
    logic [15:0] cl0, cl1;

    assign rden0 = rden && !sel;
    assign rden1 = rden && sel;
    assign ack0  = ack && !sel;
    assign ack1  = ack && sel;
    assign rxv0  = (rxv || rx_inj) && !sel;
    assign rxv1  = (rxv || rx_inj) && sel;

    logic        m_valid, m_last, m_busy, m_error, m_req, o_valid;
    logic [7:0]  m_data;
    logic [24:0] m_caddr;
    logic [15:0] m_clen;

    assign m_valid = sel ? v1 : v0;
    assign m_last  = sel ? l1 : l0;
    assign m_busy  = sel ? b1 : b0;
    assign m_error = sel ? e1 : e0;
    assign m_req   = sel ? rq1 : rq0;
    assign m_data  = sel ? d1 : d0;
    assign m_caddr = sel ? ca1 : ca0;
    assign m_clen  = sel ? cl1 : cl0;
    assign o_valid = sel ? v0 : v1;

    init_flash_rd_ctrl #(.CHUNK_BYTES(256), .TIMEOUT_CYC(TO_CYC)) dut (
        .sys_clk(clk), .glbl_rst_n(rst_n),
        .init_flash_rden(rden0), .init_flash_addr(addr), .init_flash_length(len),
        .init_flash_valid(v0), .init_flash_last(l0), .init_flash_data(d0),
        .flash_busy(b0), .flash_error(e0),
        .flash_cmd_req(rq0), .flash_cmd_addr(ca0), .flash_cmd_len(cl0), .flash_cmd_ack(ack0),
        .flash_rx_valid(rxv0), .flash_rx_data(rxd)
    );

    init_flash_rd_ctrl #(.CHUNK_BYTES(16), .TIMEOUT_CYC(TO_CYC)) dut16 (
        .sys_clk(clk), .glbl_rst_n(rst_n),
        .init_flash_rden(rden1), .init_flash_addr(addr), .init_flash_length(len),
        .init_flash_valid(v1), .init_flash_last(l1), .init_flash_data(d1),
        .flash_busy(b1), .flash_error(e1),
        .flash_cmd_req(rq1), .flash_cmd_addr(ca1), .flash_cmd_len(cl1), .flash_cmd_ack(ack1),
        .flash_rx_valid(rxv1), .flash_rx_data(rxd)
    );

    int          tests = 0;
    int          fails = 0;
    byte_t       exp_q[$];
    cmd_t        cmd_q[$];
    logic [24:0] r_addr;
    int          r_left;
    int          budget;

    // Flash content model: byte value derived from its address.
    function automatic logic [7:0] fbyte(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[24:18]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs after the edge, then drive the flash responder.
    task automatic tick();
        byte_t e;
        cmd_t  c;
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("byte_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("byte_data_last", 64'({m_data, m_last}), 64'({e.d, e.last}));
            end
        end
        if (o_valid || (m_last && !m_valid)) begin
            chk("stray_strobe", 64'({o_valid, m_last && !m_valid}), 64'(0));
        end
        ack = 1'b0;
        rxv = 1'b0;
        if (m_req) begin
            ack    = 1'b1;
            r_addr = m_caddr;
            r_left = int'(m_clen);
            chk("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
            if (cmd_q.size() != 0) begin
                c = cmd_q.pop_front();
                chk("cmd_addr", 64'(m_caddr), 64'(c.a));
                chk("cmd_len", 64'(m_clen), 64'(c.n));
            end
        end else if (r_left > 0 && budget > 0 && $urandom_range(0, 3) != 0) begin
            rxv    = 1'b1;
            rxd    = fbyte(r_addr);
            r_addr = r_addr + 25'd1;
            r_left--;
            budget--;
        end
    endtask

    task automatic start(input logic [24:0] a, input logic [23:0] n);
        addr = a;
        len  = n;
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    task automatic expect_bytes(input logic [24:0] a, input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{d: fbyte(25'(a + 25'(i))), last: with_last && (i == n - 1)});
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (m_busy && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 64'(m_busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        rst_n  = 1'b0;
        sel    = 1'b0;
        rden   = 1'b0;
        addr   = '0;
        len    = '0;
        ack    = 1'b0;
        rxv    = 1'b0;
        rx_inj = 1'b0;
        rxd    = '0;
        r_addr = '0;
        r_left = 0;
        budget = 1 << 30;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_last", 64'({v0, l0, v1, l1}), 64'(0));
        chk("rst_busy_error", 64'({b0, e0, b1, e1}), 64'(0));
        chk("rst_req", 64'({rq0, rq1}), 64'(0));
        chk("rst_cmd", 64'({ca0, cl0, d0}), 64'(0));
        rst_n = 1'b1;
        tick();

        // 1: single short burst.
        cmd_q.push_back('{a: 25'h100, n: 16'd10});
        expect_bytes(25'h100, 10, 1'b1);
        start(25'h100, 24'd10);
        chk("t1_busy", 64'(m_busy), 64'(1));
        wait_idle("t1_done", 500);
        chk("t1_bytes_left", 64'(exp_q.size()), 64'(0));
        chk("t1_cmds_left", 64'(cmd_q.size()), 64'(0));

        // 2: three chunks of 256/256/88.
        cmd_q.push_back('{a: 25'h100, n: 16'd256});
        cmd_q.push_back('{a: 25'h200, n: 16'd256});
        cmd_q.push_back('{a: 25'h300, n: 16'd88});
        expect_bytes(25'h100, 600, 1'b1);
        start(25'h100, 24'd600);
        wait_idle("t2_done", 4000);
        chk("t2_bytes_left", 64'(exp_q.size()), 64'(0));
        chk("t2_cmds_left", 64'(cmd_q.size()), 64'(0));

        // 3: chunk of 16 crossing the top of the address space.
        sel = 1'b1;
        cmd_q.push_back('{a: 25'h1FFFFF0, n: 16'd16});
        cmd_q.push_back('{a: 25'h0000000, n: 16'd16});
        expect_bytes(25'h1FFFFF0, 32, 1'b1);
        start(25'h1FFFFF0, 24'd32);
        wait_idle("t3_done", 500);
        chk("t3_error", 64'(m_error), 64'(0));
        chk("t3_bytes_left", 64'(exp_q.size()), 64'(0));
        chk("t3_cmds_left", 64'(cmd_q.size()), 64'(0));

        // 4: flash stops after 5 bytes, watchdog aborts, next rden clears the error.
        sel    = 1'b0;
        budget = 5;
        cmd_q.push_back('{a: 25'h2000, n: 16'd40});
        expect_bytes(25'h2000, 5, 1'b0);
        start(25'h2000, 24'd40);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk("t4_five_bytes", 64'(exp_q.size()), 64'(0));
        repeat (TO_CYC - 10) tick();
        chk("t4_still_busy", 64'({m_busy, m_error}), 64'(2'b10));
        wait_idle("t4_aborted", 60);
        chk("t4_error", 64'(m_error), 64'(1));
        chk("t4_req_dropped", 64'(m_req), 64'(0));
        budget = 1 << 30;
        r_left = 0;
        cmd_q.push_back('{a: 25'h40, n: 16'd3});
        expect_bytes(25'h40, 3, 1'b1);
        start(25'h40, 24'd3);
        chk("t4_error_cleared", 64'(m_error), 64'(0));
        wait_idle("t4_next_done", 200);
        chk("t4_next_bytes_left", 64'(exp_q.size()), 64'(0));

        // 5: rden while busy is ignored; zero-length rden and idle rx are ignored.
        cmd_q.push_back('{a: 25'h500, n: 16'd20});
        expect_bytes(25'h500, 20, 1'b1);
        start(25'h500, 24'd20);
        repeat (3) tick();
        start(25'h9999, 24'd5);
        repeat (6) tick();
        start(25'h1234, 24'd7);
        wait_idle("t5_done", 500);
        chk("t5_bytes_left", 64'(exp_q.size()), 64'(0));
        start(25'h77, 24'd0);
        chk("t5_len0_idle", 64'({m_busy, m_req}), 64'(0));
        rxd    = 8'h5A;
        rx_inj = 1'b1;
        tick();
        rx_inj = 1'b0;
        chk("t5_idle_rx_dropped", 64'(m_valid), 64'(0));
        repeat (3) tick();
        chk("t5_cmds_left", 64'(cmd_q.size()), 64'(0));

        // 6: reset mid-RECV, then a fresh 4-byte burst.
        cmd_q.push_back('{a: 25'h700, n: 16'd50});
        expect_bytes(25'h700, 50, 1'b1);
        start(25'h700, 24'd50);
        k = 0;
        while (exp_q.size() > 40 && k < 200) begin
            tick();
            k++;
        end
        chk("t6_midburst", 64'(m_busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 64'({m_valid, m_last, m_busy, m_req, m_error}), 64'(0));
        chk("t6_rst_cmd", 64'({m_caddr, m_clen, m_data}), 64'(0));
        exp_q.delete();
        cmd_q.delete();
        r_left = 0;
        ack    = 1'b0;
        rxv    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_q.push_back('{a: 25'h10, n: 16'd4});
        expect_bytes(25'h10, 4, 1'b1);
        start(25'h10, 24'd4);
        wait_idle("t6_done", 200);
        chk("t6_bytes_left", 64'(exp_q.size()), 64'(0));
        chk("t6_cmds_left", 64'(cmd_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
